// File: rtl/game_pkg.sv
// Shared codes for the game FSM interface and the player status monitor.
// gameStatus codes, verdict codes, death causes and the monitor state encoding.
package game_pkg;

    localparam logic [2:0] GS_START     = 3'd0;
    localparam logic [2:0] GS_PLAY      = 3'd1;
    localparam logic [2:0] GS_LEVEL_INC = 3'd2;
    localparam logic [2:0] GS_WORLD_INC = 3'd3;
    localparam logic [2:0] GS_LIVES_DEC = 3'd4;
    localparam logic [2:0] GS_LOSE      = 3'd5;
    localparam logic [2:0] GS_WIN       = 3'd6;

    localparam logic [1:0] PS_PLAYING = 2'd0;
    localparam logic [1:0] PS_PASS    = 2'd1;
    localparam logic [1:0] PS_DIED    = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_HAZARD  = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_RUN     = 3'd2,
        ST_PASS    = 3'd3,
        ST_DEAD    = 3'd4,
        ST_HOLDOFF = 3'd5
    } mon_state_t;

    // Saturating increment used by the debounce counters.
    function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] lim);
        return (v >= lim) ? lim : v + 3'd1;
    endfunction

endpackage

// File: rtl/level_timer.sv
// Per-level countdown: divides frame_tick down to seconds and counts time_left to zero.
// load wins over run; time_left saturates at zero.
module level_timer
    import game_pkg::*;
#(
    parameter int TIME_LIMIT     = 99,
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       run,
    input  logic       frame_tick,
    output logic [6:0] time_left,
    output logic       expired
);

    localparam logic [6:0] TL_INIT  = 7'(TIME_LIMIT);
    localparam logic [7:0] FPS_LAST = 8'(FRAMES_PER_SEC - 1);

    logic [7:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt <= 8'd0;
            time_left <= TL_INIT;
        end else if (load) begin
            frame_cnt <= 8'd0;
            time_left <= TL_INIT;
        end else if (run && frame_tick) begin
            if (frame_cnt == FPS_LAST) begin
                frame_cnt <= 8'd0;
                if (time_left != 7'd0) begin
                    time_left <= time_left - 7'd1;
                end
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign expired = (time_left == 7'd0);

endmodule

// File: rtl/player_status_monitor.sv
// Filters hazard/goal contact per frame, runs the level countdown and holds the verdict
// (0 playing, 1 levelPass, 2 died) for the game FSM while it sits in playGame.
module player_status_monitor
    import game_pkg::*;
#(
    parameter int TIME_LIMIT     = 99,
    parameter int FRAMES_PER_SEC = 60,
    parameter int HIT_FRAMES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [2:0] game_status,
    input  logic       hazard_hit,
    input  logic       goal_reached,
    output logic [1:0] player_status,
    output logic [1:0] death_cause,
    output logic [6:0] time_left
);

    localparam logic [2:0] HIT = 3'(HIT_FRAMES);

    mon_state_t state;
    logic [2:0] hazard_cnt;
    logic [2:0] goal_cnt;
    logic       goal_seen_low;
    logic       expired;
    logic       in_play;
    logic       timer_load;
    logic       timer_run;

    assign in_play    = (game_status == GS_PLAY);
    assign timer_load = (state == ST_IDLE) || (state == ST_ARM);
    assign timer_run  = (state == ST_RUN);

    level_timer #(
        .TIME_LIMIT     (TIME_LIMIT),
        .FRAMES_PER_SEC (FRAMES_PER_SEC)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .run        (timer_run),
        .frame_tick (frame_tick),
        .time_left  (time_left),
        .expired    (expired)
    );

    // A goal overlap only counts after the player has been seen off the goal once,
    // so spawning on top of a goal cannot pass the level instantly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hazard_cnt    <= 3'd0;
            goal_cnt      <= 3'd0;
            goal_seen_low <= 1'b0;
        end else if (state == ST_ARM) begin
            hazard_cnt    <= 3'd0;
            goal_cnt      <= 3'd0;
            goal_seen_low <= 1'b0;
        end else if (state == ST_RUN && frame_tick) begin
            hazard_cnt <= hazard_hit ? sat_inc(hazard_cnt, HIT) : 3'd0;
            if (!goal_reached) begin
                goal_seen_low <= 1'b1;
                goal_cnt      <= 3'd0;
            end else if (goal_seen_low) begin
                goal_cnt <= sat_inc(goal_cnt, HIT);
            end else begin
                goal_cnt <= 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            player_status <= PS_PLAYING;
            death_cause   <= CAUSE_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    player_status <= PS_PLAYING;
                    death_cause   <= CAUSE_NONE;
                    if (in_play) state <= ST_ARM;
                end
                ST_ARM: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    // Abort first, then death beats pass when both qualify together.
                    if (!in_play) begin
                        state         <= ST_IDLE;
                        player_status <= PS_PLAYING;
                        death_cause   <= CAUSE_NONE;
                    end else if (hazard_cnt == HIT) begin
                        state         <= ST_DEAD;
                        player_status <= PS_DIED;
                        death_cause   <= CAUSE_HAZARD;
                    end else if (expired) begin
                        state         <= ST_DEAD;
                        player_status <= PS_DIED;
                        death_cause   <= CAUSE_TIMEOUT;
                    end else if (goal_cnt == HIT) begin
                        state         <= ST_PASS;
                        player_status <= PS_PASS;
                    end
                end
                ST_PASS: begin
                    if (!in_play) begin
                        state         <= ST_HOLDOFF;
                        player_status <= PS_PLAYING;
                    end
                end
                ST_DEAD: begin
                    if (!in_play) begin
                        state         <= ST_HOLDOFF;
                        player_status <= PS_PLAYING;
                        death_cause   <= CAUSE_NONE;
                    end
                end
                ST_HOLDOFF: begin
                    player_status <= PS_PLAYING;
                    death_cause   <= CAUSE_NONE;
                    if (!in_play) state <= ST_IDLE;
                end
                default: begin
                    state         <= ST_IDLE;
                    player_status <= PS_PLAYING;
                    death_cause   <= CAUSE_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_status_monitor.sv
// Directed bench for player_status_monitor: default-parameter instance plus a short-timer
// instance (TIME_LIMIT=2, FRAMES_PER_SEC=4) for the timeout path.
module tb_player_status_monitor;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic [2:0] game_status;
    logic [2:0] game_status_t;
    logic       hazard_hit;
    logic       goal_reached;
    logic [1:0] player_status;
    logic [1:0] death_cause;
    logic [6:0] time_left;
    logic [1:0] player_status_t;
    logic [1:0] death_cause_t;
    logic [6:0] time_left_t;

    int total;
    int bad;

    player_status_monitor dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .game_status   (game_status),
        .hazard_hit    (hazard_hit),
        .goal_reached  (goal_reached),
        .player_status (player_status),
        .death_cause   (death_cause),
        .time_left     (time_left)
    );

    player_status_monitor #(
        .TIME_LIMIT     (2),
        .FRAMES_PER_SEC (4),
        .HIT_FRAMES     (2)
    ) dut_t (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .game_status   (game_status_t),
        .hazard_hit    (hazard_hit),
        .goal_reached  (goal_reached),
        .player_status (player_status_t),
        .death_cause   (death_cause_t),
        .time_left     (time_left_t)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: inputs change on the falling edge, outputs sampled there too
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick(input logic hz, input logic gl);
        @(negedge clk);
        frame_tick   = 1'b1;
        hazard_hit   = hz;
        goal_reached = gl;
        @(negedge clk);
        frame_tick   = 1'b0;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        frame_tick    = 1'b0;
        game_status   = 3'd0;
        game_status_t = 3'd0;
        hazard_hit    = 1'b0;
        goal_reached  = 1'b0;

        // 1: reset
        wait_clk(3);
        check("rst_status", player_status, 0);
        check("rst_time", time_left, 99);
        check("rst_cause", death_cause, 0);
        check("rst_time_t", time_left_t, 2);
        reset = 1'b1;
        wait_clk(2);
        check("idle_status", player_status, 0);

        // 2: level pass after the goal is seen low once then held for two ticks
        game_status = 3'd1;
        wait_clk(2);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("goal_no_low_yet", player_status, 0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("pass_latency", player_status, 0);
        wait_clk(1);
        check("pass_status", player_status, 1);
        check("pass_cause", death_cause, 0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        wait_clk(2);
        check("pass_frozen", player_status, 1);
        goal_reached = 1'b0;
        hazard_hit   = 1'b0;
        game_status  = 3'd2;
        wait_clk(2);
        check("pass_release", player_status, 0);
        wait_clk(2);

        // 3: single hazard frame is filtered, two consecutive frames kill
        game_status = 3'd1;
        wait_clk(2);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        wait_clk(2);
        check("hazard_glitch", player_status, 0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        wait_clk(2);
        check("hazard_status", player_status, 2);
        check("hazard_cause", death_cause, 1);
        hazard_hit = 1'b0;
        tick(1'b0, 1'b0);
        check("dead_time_frozen", time_left, 99);
        game_status = 3'd0;
        wait_clk(2);
        check("dead_release", player_status, 0);
        check("dead_release_cause", death_cause, 0);
        wait_clk(2);

        // 5: hazard and goal qualify together, death wins
        game_status = 3'd1;
        wait_clk(2);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        wait_clk(1);
        check("both_status_early", player_status, 2);
        wait_clk(2);
        check("both_status", player_status, 2);
        check("both_cause", death_cause, 1);
        hazard_hit   = 1'b0;
        goal_reached = 1'b0;
        game_status  = 3'd0;
        wait_clk(3);

        // 4: timeout on the short-timer instance
        game_status_t = 3'd1;
        wait_clk(2);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        check("t_time_3", time_left_t, 2);
        tick(1'b0, 1'b0);
        check("t_time_4", time_left_t, 1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        check("t_time_7", time_left_t, 1);
        check("t_status_7", player_status_t, 0);
        tick(1'b0, 1'b0);
        check("t_time_8", time_left_t, 0);
        wait_clk(2);
        check("t_status", player_status_t, 2);
        check("t_cause", death_cause_t, 2);
        tick(1'b0, 1'b0);
        check("t_time_sat", time_left_t, 0);
        game_status_t = 3'd0;
        wait_clk(3);
        check("t_release", player_status_t, 0);
        check("t_idle_time", time_left_t, 2);

        // 6: reset mid-level, then re-arm
        game_status = 3'd1;
        wait_clk(2);
        for (int i = 0; i < 59; i++) tick(1'b0, 1'b0);
        check("sec_boundary_59", time_left, 99);
        tick(1'b0, 1'b0);
        check("sec_boundary_60", time_left, 98);
        tick(1'b1, 1'b0);
        reset = 1'b0;
        wait_clk(1);
        reset = 1'b1;
        hazard_hit = 1'b0;
        check("midrst_status", player_status, 0);
        check("midrst_cause", death_cause, 0);
        check("midrst_time", time_left, 99);
        wait_clk(2);
        tick(1'b1, 1'b0);
        check("rearm_one_hit", player_status, 0);
        tick(1'b1, 1'b0);
        wait_clk(2);
        check("rearm_time", time_left, 99);
        check("rearm_status", player_status, 2);
        check("rearm_cause", death_cause, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
